// File: rtl/bcd_count_ctrl.sv
// Debounced up/down pushbutton counter with parallel load, bounded to 0..MAX_VAL.
// Feeds the 7-bit binary input of bcd2driver.

module bcd_debounce_fsm #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic s,
  output logic step,
  output logic active
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // cnt counts consecutive stable samples; a single opposite sample aborts the run.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS;
            cnt   <= CNT_ONE;
          end
        end
        PRESS: begin
          if (!s) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            step  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!s) begin
            state <= RELEASE;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE: begin
          if (s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign active = (state != IDLE);

endmodule

module bcd_count_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_VAL         = 99,
  parameter int WRAP            = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       load,
  input  logic [6:0] load_val,
  output logic [6:0] value,
  output logic       wrap_pulse,
  output logic       busy
);
  localparam logic [6:0] MAX = 7'(MAX_VAL);
  localparam logic [6:0] ONE = 7'd1;

  logic [1:0] up_sync;
  logic [1:0] dn_sync;
  logic       up_step;
  logic       dn_step;
  logic       up_active;
  logic       dn_active;

  // Two-flop synchronisers for the asynchronous raw buttons.
  always_ff @(posedge clock) begin
    if (reset) begin
      up_sync <= 2'b00;
      dn_sync <= 2'b00;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_dn};
    end
  end

  bcd_debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clock  (clock),
    .reset  (reset),
    .s      (up_sync[1]),
    .step   (up_step),
    .active (up_active)
  );

  bcd_debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clock  (clock),
    .reset  (reset),
    .s      (dn_sync[1]),
    .step   (dn_step),
    .active (dn_active)
  );

  // Load beats any step; opposing steps in one cycle cancel.
  always_ff @(posedge clock) begin
    if (reset) begin
      value      <= 7'd0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (load) begin
        value <= (load_val > MAX) ? MAX : load_val;
      end else if (up_step && dn_step) begin
        value <= value;
      end else if (up_step) begin
        if (value == MAX) begin
          value      <= (WRAP != 0) ? 7'd0 : MAX;
          wrap_pulse <= 1'b1;
        end else begin
          value <= value + ONE;
        end
      end else if (dn_step) begin
        if (value == 7'd0) begin
          value      <= (WRAP != 0) ? MAX : 7'd0;
          wrap_pulse <= 1'b1;
        end else begin
          value <= value - ONE;
        end
      end
    end
  end

  assign busy = up_active | dn_active;

endmodule
